coef_responder: RTL and testbench

- Responder side of the ANN coefficient-request interface.
- Accepts request_coef/coef_select from the ANN controller and fetches the selected block (image or first-layer weights) word by word from external 16-bit memory.
- Streams each word into the ANN storage write port, then reports completion.
- Sits between the ANN core and the memory/verification side; owns all address generation and sequencing.

---
 rtl/coef_pkg.sv | 21 ++
 rtl/coef_addr_gen.sv | 76 +++++++
 rtl/coef_responder.sv | 181 ++++++++++++++++++
 tb/tb_coef_responder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_pkg.sv
// Shared types and constants for the ANN coefficient responder.
// Holds the FSM state encoding, select codes and default block geometry.
package coef_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      FINISH
   } state_t;

   localparam logic [1:0] SEL_IMAGE   = 2'b00;
   localparam logic [1:0] SEL_WEIGHTS = 2'b01;

   localparam int DEF_IMAGE_SIZE  = 64;
   localparam int DEF_FIRST_LAYER = 16;

   localparam int ROW_W = 4;
   localparam int COL_W = 6;

endpackage

// File: rtl/coef_addr_gen.sv
// Row/column word counters and memory address generation for one block.
// Ports: clk, rst; clear (start block, latch base and select), advance (next
// word), weights/image_address (block selection), addr, row, col, last.
import coef_pkg::*;

module coef_addr_gen #(
   parameter int                IMAGE_SIZE  = DEF_IMAGE_SIZE,
   parameter int                FIRST_LAYER = DEF_FIRST_LAYER,
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] WEIGHT_BASE = 16'hC000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   input  logic              weights,
   input  logic [9:0]        image_address,
   output logic [ADDR_W-1:0] addr,
   output logic [ROW_W-1:0]  row,
   output logic [COL_W-1:0]  col,
   output logic              last
);

   logic [ROW_W-1:0]  row_q;
   logic [COL_W-1:0]  col_q;
   logic              wts_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_d;
   logic [31:0]       base_w;
   logic              col_last;
   logic              row_last;

   // Base is latched at accept so the inputs may change mid-transfer.
   always_comb begin
      base_w = '0;
      if (weights) begin
         base_w = 32'(WEIGHT_BASE);
      end else begin
         base_w = 32'(image_address) * 32'(IMAGE_SIZE);
      end
      base_d = ADDR_W'(base_w);
   end

   assign col_last = (col_q == COL_W'(IMAGE_SIZE - 1));
   assign row_last = wts_q ? (row_q == ROW_W'(FIRST_LAYER - 1))
                           : (row_q == '0);
   assign last     = col_last && row_last;

   assign addr = ADDR_W'(32'(base_q)
                       + 32'(row_q) * 32'(IMAGE_SIZE)
                       + 32'(col_q));
   assign row  = row_q;
   assign col  = col_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         row_q  <= '0;
         col_q  <= '0;
         wts_q  <= 1'b0;
         base_q <= '0;
      end else if (clear) begin
         row_q  <= '0;
         col_q  <= '0;
         wts_q  <= weights;
         base_q <= base_d;
      end else if (advance) begin
         if (col_last) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/coef_responder.sv
// Responder for ANN coefficient requests: fetches an image or the weight
// block word by word from 16-bit memory and streams it into ANN storage.
// Ports: clk, rst (sync, active high); request_coef, coef_select,
// image_address from the controller; mem_addr/mem_ren/mem_rdata/mem_rvalid
// to memory; wr_en/wr_row/wr_col/wr_data to storage; busy, loaded, error.
// Build option: COEF_TIMEOUT_EN enables an rvalid watchdog (TIMEOUT cycles).
import coef_pkg::*;

module coef_responder #(
   parameter int                IMAGE_SIZE  = DEF_IMAGE_SIZE,
   parameter int                FIRST_LAYER = DEF_FIRST_LAYER,
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] WEIGHT_BASE = 16'hC000
`ifdef COEF_TIMEOUT_EN
   ,
   parameter int                TIMEOUT     = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request_coef,
   input  logic [1:0]        coef_select,
   input  logic [9:0]        image_address,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_ren,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic              wr_en,
   output logic [ROW_W-1:0]  wr_row,
   output logic [COL_W-1:0]  wr_col,
   output logic [15:0]       wr_data,
   output logic              busy,
   output logic              loaded,
   output logic              error
);

   state_t state_q, state_d;

   logic busy_q, busy_d;
   logic loaded_q, loaded_d;
   logic error_q, error_d;
   logic wr_en_q, wr_en_d;
   logic [ROW_W-1:0] wr_row_q;
   logic [COL_W-1:0] wr_col_q;
   logic [15:0]      wr_data_q;

   logic clear;
   logic advance;
   logic capture;
   logic tmo_hit;
   logic legal_sel;

   logic [ADDR_W-1:0] gen_addr;
   logic [ROW_W-1:0]  gen_row;
   logic [COL_W-1:0]  gen_col;
   logic              gen_last;

   coef_addr_gen #(
      .IMAGE_SIZE  (IMAGE_SIZE),
      .FIRST_LAYER (FIRST_LAYER),
      .ADDR_W      (ADDR_W),
      .WEIGHT_BASE (WEIGHT_BASE)
   ) u_addr_gen (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear),
      .advance       (advance),
      .weights       (coef_select == SEL_WEIGHTS),
      .image_address (image_address),
      .addr          (gen_addr),
      .row           (gen_row),
      .col           (gen_col),
      .last          (gen_last)
   );

   assign legal_sel = (coef_select == SEL_IMAGE)
                   || (coef_select == SEL_WEIGHTS);

`ifdef COEF_TIMEOUT_EN
   // Counts WAIT cycles for the current word; restarts on every ISSUE.
   logic [7:0] tmo_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
      end else if (state_q == ISSUE) begin
         tmo_q <= '0;
      end else if (state_q == WAIT) begin
         tmo_q <= tmo_q + 8'd1;
      end
   end

   assign tmo_hit = (tmo_q == 8'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      error_d  = error_q;
      loaded_d = 1'b0;
      wr_en_d  = 1'b0;
      capture  = 1'b0;
      clear    = 1'b0;
      advance  = 1'b0;
      mem_ren  = 1'b0;
      mem_addr = '0;
      unique case (state_q)
         IDLE: begin
            if (request_coef) begin
               if (legal_sel) begin
                  clear   = 1'b1;
                  error_d = 1'b0;
                  busy_d  = 1'b1;
                  state_d = ISSUE;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            mem_ren  = 1'b1;
            mem_addr = gen_addr;
            state_d  = WAIT;
         end
         WAIT: begin
            if (mem_rvalid) begin
               wr_en_d = 1'b1;
               capture = 1'b1;
               advance = 1'b1;
               state_d = gen_last ? FINISH : ISSUE;
            end else if (tmo_hit) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         FINISH: begin
            // loaded is registered so it lands after the final wr_en.
            busy_d   = 1'b0;
            loaded_d = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         loaded_q  <= 1'b0;
         error_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_row_q  <= '0;
         wr_col_q  <= '0;
         wr_data_q <= '0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         loaded_q <= loaded_d;
         error_q  <= error_d;
         wr_en_q  <= wr_en_d;
         if (capture) begin
            wr_row_q  <= gen_row;
            wr_col_q  <= gen_col;
            wr_data_q <= mem_rdata;
         end
      end
   end

   assign busy    = busy_q;
   assign loaded  = loaded_q;
   assign error   = error_q;
   assign wr_en   = wr_en_q;
   assign wr_row  = wr_row_q;
   assign wr_col  = wr_col_q;
   assign wr_data = wr_data_q;

endmodule

// File: tb/tb_coef_responder.sv
// Directed bench for coef_responder: table of block transfers plus
// hand sequences for reset abort, request spam and a withheld rvalid.
module tb_coef_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        request_coef = 1'b0;
   logic [1:0]  coef_select = 2'b00;
   logic [9:0]  image_address = '0;
   logic [15:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic [15:0] mem_addr;
   logic        mem_ren;
   logic        wr_en;
   logic [3:0]  wr_row;
   logic [5:0]  wr_col;
   logic [15:0] wr_data;
   logic        busy;
   logic        loaded;
   logic        error;

   coef_responder dut (
      .clk           (clk),
      .rst           (rst),
      .request_coef  (request_coef),
      .coef_select   (coef_select),
      .image_address (image_address),
      .mem_addr      (mem_addr),
      .mem_ren       (mem_ren),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .wr_en         (wr_en),
      .wr_row        (wr_row),
      .wr_col        (wr_col),
      .wr_data       (wr_data),
      .busy          (busy),
      .loaded        (loaded),
      .error         (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [9:0]  img;
      int          lat_min;
      int          lat_max;
      bit          exp_err;
      int          exp_writes;
      logic [15:0] first_addr;
      logic [15:0] last_addr;
      int          exp_cycles;
   } vec_t;

   vec_t vecs[7];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   bit          mon_wts = 1'b0;
   logic [15:0] mon_base = '0;
   int          wr_idx = 0;
   int          ren_idx = 0;
   int          loaded_cnt = 0;
   logic [15:0] last_ren = '0;

   int          lat_min = 1;
   int          lat_max = 1;
   bit          hold_en = 1'b0;
   logic [15:0] hold_addr = '0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Monitor: address, write stream and loaded pulses, sampled mid-cycle.
   initial begin
      int          r;
      int          c;
      logic [15:0] d;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mem_ren) begin
               chk("ren_addr", 32'(mem_addr), 32'(mon_base + 16'(ren_idx)));
               last_ren = mem_addr;
               ren_idx++;
            end
            if (wr_en) begin
               r = mon_wts ? wr_idx / 64 : 0;
               c = wr_idx % 64;
               d = (mon_base + 16'(wr_idx)) ^ 16'h5A5A;
               chk("wr_row", 32'(wr_row), 32'(r));
               chk("wr_col", 32'(wr_col), 32'(c));
               chk("wr_data", 32'(wr_data), 32'(d));
               wr_idx++;
            end
            if (loaded) begin
               loaded_cnt++;
               chk("loaded_without_wr_en", 32'(wr_en), 32'd0);
            end
         end
      end
   end

   // Memory: returns addr ^ 5A5A after lat_min..lat_max cycles.
   initial begin
      logic [15:0] a;
      int          lat;
      #1;
      forever begin
         if (mem_ren && !rst && !(hold_en && mem_addr == hold_addr)) begin
            a   = mem_addr;
            lat = $urandom_range(lat_max, lat_min);
            repeat (lat) @(posedge clk);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = a ^ 16'h5A5A;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
         end else begin
            @(posedge clk);
            #1;
         end
      end
   end

   task automatic mon_start(input bit wts, input logic [15:0] base);
      mon_wts    = wts;
      mon_base   = base;
      wr_idx     = 0;
      ren_idx    = 0;
      loaded_cnt = 0;
   endtask

   task automatic run_vec(input vec_t v);
      int c0;
      int n;
      mon_start(v.sel == 2'b01, v.first_addr);
      lat_min       = v.lat_min;
      lat_max       = v.lat_max;
      request_coef  = 1'b1;
      coef_select   = v.sel;
      image_address = v.img;
      c0            = cyc;
      @(posedge clk);
      #1;
      request_coef = 1'b0;
      if (v.exp_err) begin
         chk("err_flag", 32'(error), 32'd1);
         chk("err_busy", 32'(busy), 32'd0);
         repeat (5) @(posedge clk);
         #1;
         chk("err_no_ren", 32'(ren_idx), 32'd0);
         chk("err_no_loaded", 32'(loaded_cnt), 32'd0);
         chk("err_sticky", 32'(error), 32'd1);
      end else begin
         chk("accept_busy", 32'(busy), 32'd1);
         chk("accept_err_clear", 32'(error), 32'd0);
         n = 0;
         while (!loaded && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
         end
         chk("loaded_seen", 32'(loaded), 32'd1);
         if (v.exp_cycles > 0) begin
            chk("latency", 32'(cyc - c0), 32'(v.exp_cycles));
         end
         chk("write_count", 32'(wr_idx), 32'(v.exp_writes));
         chk("ren_count", 32'(ren_idx), 32'(v.exp_writes));
         chk("last_addr", 32'(last_ren), 32'(v.last_addr));
         chk("busy_done", 32'(busy), 32'd0);
         repeat (3) @(posedge clk);
         #1;
         chk("one_loaded", 32'(loaded_cnt), 32'd1);
         chk("loaded_pulse_end", 32'(loaded), 32'd0);
      end
   endtask

   initial begin
      int n;
      int w;
      int r;

      vecs[0] = '{2'b00, 10'd3,    1, 1, 1'b0,   64, 16'h00C0, 16'h00FF,  130};
      vecs[1] = '{2'b01, 10'd0,    1, 5, 1'b0, 1024, 16'hC000, 16'hC3FF,   -1};
      vecs[2] = '{2'b10, 10'd0,    1, 1, 1'b1,    0, 16'h0000, 16'h0000,   -1};
      vecs[3] = '{2'b00, 10'd5,    1, 1, 1'b0,   64, 16'h0140, 16'h017F,  130};
      vecs[4] = '{2'b11, 10'd9,    1, 1, 1'b1,    0, 16'h0000, 16'h0000,   -1};
      vecs[5] = '{2'b00, 10'd1023, 2, 2, 1'b0,   64, 16'hFFC0, 16'hFFFF,  194};
      vecs[6] = '{2'b01, 10'd0,    1, 1, 1'b0, 1024, 16'hC000, 16'hC3FF, 2050};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctrl", 32'({mem_ren, wr_en, busy, loaded, error}), 32'd0);
      chk("reset_bus", 32'(|{mem_addr, wr_row, wr_col, wr_data}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
      end

      // Reset in the middle of a weight load.
      mon_start(1'b1, 16'hC000);
      lat_min       = 1;
      lat_max       = 3;
      request_coef  = 1'b1;
      coef_select   = 2'b01;
      @(posedge clk);
      #1;
      request_coef = 1'b0;
      n = 0;
      while (wr_idx < 20 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("rst_reached_word20", 32'(wr_idx >= 20), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_ctrl", 32'({mem_ren, wr_en, busy, loaded, error}), 32'd0);
      chk("rst_mid_bus", 32'(|{mem_addr, wr_row, wr_col, wr_data}), 32'd0);
      rst = 1'b0;
      w = wr_idx;
      r = ren_idx;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_no_write", 32'(wr_idx), 32'(w));
      chk("rst_no_ren", 32'(ren_idx), 32'(r));
      chk("rst_no_loaded", 32'(loaded_cnt), 32'd0);
      run_vec(vecs[0]);

      // Request strobes while busy must be ignored.
      mon_start(1'b0, 16'h01C0);
      lat_min       = 1;
      lat_max       = 2;
      request_coef  = 1'b1;
      coef_select   = 2'b00;
      image_address = 10'd7;
      @(posedge clk);
      #1;
      request_coef = 1'b0;
      coef_select  = 2'b01;
      n = 0;
      while (n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         if (loaded) break;
         request_coef = busy && (n % 3 == 0);
      end
      request_coef = 1'b0;
      chk("spam_loaded", 32'(loaded), 32'd1);
      chk("spam_writes", 32'(wr_idx), 32'd64);
      chk("spam_last_addr", 32'(last_ren), 32'h01FF);
      repeat (6) @(posedge clk);
      #1;
      chk("spam_one_loaded", 32'(loaded_cnt), 32'd1);
      chk("spam_busy_low", 32'(busy), 32'd0);
      chk("spam_no_error", 32'(error), 32'd0);

      // Memory withholds rvalid for word 5 of an image.
      mon_start(1'b0, 16'h00C0);
      lat_min       = 1;
      lat_max       = 1;
      hold_en       = 1'b1;
      hold_addr     = 16'h00C5;
      request_coef  = 1'b1;
      coef_select   = 2'b00;
      image_address = 10'd3;
      @(posedge clk);
      #1;
      request_coef = 1'b0;
`ifdef COEF_TIMEOUT_EN
      n = 0;
      while (!error && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("tmo_error", 32'(error), 32'd1);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_window", 32'(n >= 255 && n <= 300), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("tmo_writes", 32'(wr_idx), 32'd5);
      chk("tmo_no_loaded", 32'(loaded_cnt), 32'd0);
`else
      repeat (400) @(posedge clk);
      #1;
      chk("hang_busy", 32'(busy), 32'd1);
      chk("hang_no_error", 32'(error), 32'd0);
      chk("hang_writes", 32'(wr_idx), 32'd5);
      chk("hang_no_loaded", 32'(loaded_cnt), 32'd0);
`endif
      hold_en = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      run_vec(vecs[3]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
